fft_seq_ctrl: RTL and testbench

Top-level sequencer for the FFT accelerator. It accepts a start command (FFT or IFFT) from the host, latches the signal number, and steps the datapath through input load, RAM load, the butterfly stages, output buffering and write-back. It emits the per-phase enables and the stage/cycle counters that the FFT RAM, twiddle ROM and in/out FIFOs consume. It holds no sample data.

---
 rtl/fft_seq_ctrl.sv | 256 +++++++++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fft_seq_ctrl
// Description : Top-level sequencer for the FFT accelerator. Accepts an FFT or
//               IFFT start command, latches the signal number and direction,
//               then steps the datapath through input wait, RAM load,
//               butterfly stages, optional filter pass, output buffering and
//               write-back. Drives the per-phase enables and the stage/cycle
//               counters used by the FFT RAM, twiddle ROM and in/out FIFOs.
//               Holds no sample data.
//
// Optional feature macro: FFT_CTRL_FILTER_EN
//   defined   -> FILT state present; a latched filter bit adds
//                CYCLES_PER_STAGE cycles of filterActive after CALC.
//   undefined -> no FILT state, filter input ignored, filterActive tied 0.
//
// Ports:
//   clk              in   system clock
//   rst              in   synchronous active-high reset
//   startF / startI  in   start forward / inverse transform (startF wins)
//   filter           in   filter pass request, sampled with the start
//   sigNum[17:0]     in   signal number for this transform
//   inFifoReady      in   in FIFO holds a full block
//   loadExternalDone in   RAM load from in FIFO complete
//   accelWrBlkDone   in   memory controller drained the out FIFO
//   calculating      out  accelerator busy (any state but IDLE)
//   isIFFT           out  latched transform direction
//   sigNumMC[17:0]   out  latched signal number
//   loadExternal     out  in FIFO -> FFT RAM
//   loadInternal     out  butterfly datapath active
//   stageCount[4:0]  out  current butterfly stage
//   cycleCount[8:0]  out  current cycle within stage / filter pass
//   filterActive     out  filter pass active
//   doneCalculating  out  one-cycle pulse: compute finished
//   loadOutBuffer    out  FFT RAM -> out FIFO
//   done             out  one-cycle pulse: transform retired
//
// Revision    : 1.0 - initial release
// ============================================================================
module fft_seq_ctrl #(
    parameter int NUM_STAGES       = 10,
    parameter int CYCLES_PER_STAGE = 512,
    parameter int OUT_BEATS        = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startF,
    input  logic        startI,
    input  logic        filter,
    input  logic [17:0] sigNum,
    input  logic        inFifoReady,
    input  logic        loadExternalDone,
    input  logic        accelWrBlkDone,
    output logic        calculating,
    output logic        isIFFT,
    output logic [17:0] sigNumMC,
    output logic        loadExternal,
    output logic        loadInternal,
    output logic [4:0]  stageCount,
    output logic [8:0]  cycleCount,
    output logic        filterActive,
    output logic        doneCalculating,
    output logic        loadOutBuffer,
    output logic        done
);

    localparam logic [4:0] c_STAGE_LAST = 5'(NUM_STAGES - 1);
    localparam logic [8:0] c_CYCLE_LAST = 9'(CYCLES_PER_STAGE - 1);
    localparam logic [9:0] c_BEAT_LAST  = 10'(OUT_BEATS - 1);

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WAIT_IN  = 4'd1,
        S_LOAD_EXT = 4'd2,
        S_CALC     = 4'd3,
`ifdef FFT_CTRL_FILTER_EN
        S_FILT     = 4'd4,
`endif
        S_CDONE    = 4'd5,
        S_LOAD_OUT = 4'd6,
        S_WAIT_WB  = 4'd7,
        S_DONE     = 4'd8
    } state_t;

    state_t      r_state;
    state_t      w_nxtState;
    state_t      w_calcExit;

    logic [4:0]  r_stage;
    logic [8:0]  r_cycle;
    logic [9:0]  r_beat;
    logic [4:0]  w_nxtStage;
    logic [8:0]  w_nxtCycle;
    logic [9:0]  w_nxtBeat;

    logic [17:0] r_sigNumMC;
    logic [17:0] w_nxtSigNum;
    logic        r_isIFFT;
    logic        w_nxtIsIfft;
    logic        w_start;

    logic        r_calculating;
    logic        r_loadExternal;
    logic        r_loadInternal;
    logic        r_doneCalculating;
    logic        r_loadOutBuffer;
    logic        r_done;

    assign w_start = startF | startI;

`ifdef FFT_CTRL_FILTER_EN
    logic r_filter;
    logic r_filterActive;

    // The filter request travels with the start and is only consulted at
    // the end of the last butterfly stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_filter       <= 1'b0;
            r_filterActive <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_start) begin
                r_filter <= filter;
            end
            r_filterActive <= (w_nxtState == S_FILT);
        end
    end

    assign w_calcExit   = r_filter ? S_FILT : S_CDONE;
    assign filterActive = r_filterActive;
`else
    logic w_unusedFilter;
    assign w_unusedFilter = filter;
    assign w_calcExit     = S_CDONE;
    assign filterActive   = 1'b0;
`endif

    // Next-state and next-counter logic. Counters default to zero so they
    // read 0 in every phase that does not explicitly advance them.
    always_comb begin
        w_nxtState  = r_state;
        w_nxtStage  = '0;
        w_nxtCycle  = '0;
        w_nxtBeat   = '0;
        w_nxtSigNum = r_sigNumMC;
        w_nxtIsIfft = r_isIFFT;

        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_nxtState  = S_WAIT_IN;
                    w_nxtSigNum = sigNum;
                    // Simultaneous starts resolve to a forward transform.
                    w_nxtIsIfft = startI & ~startF;
                end
            end
            S_WAIT_IN: begin
                if (inFifoReady) begin
                    w_nxtState = S_LOAD_EXT;
                end
            end
            S_LOAD_EXT: begin
                if (loadExternalDone) begin
                    w_nxtState = S_CALC;
                end
            end
            S_CALC: begin
                if (r_cycle == c_CYCLE_LAST) begin
                    if (r_stage == c_STAGE_LAST) begin
                        w_nxtState = w_calcExit;
                    end else begin
                        w_nxtStage = r_stage + 5'd1;
                    end
                end else begin
                    w_nxtStage = r_stage;
                    w_nxtCycle = r_cycle + 9'd1;
                end
            end
`ifdef FFT_CTRL_FILTER_EN
            S_FILT: begin
                if (r_cycle == c_CYCLE_LAST) begin
                    w_nxtState = S_CDONE;
                end else begin
                    w_nxtCycle = r_cycle + 9'd1;
                end
            end
`endif
            S_CDONE: begin
                w_nxtState = S_LOAD_OUT;
            end
            S_LOAD_OUT: begin
                if (r_beat == c_BEAT_LAST) begin
                    w_nxtState = S_WAIT_WB;
                end else begin
                    w_nxtBeat = r_beat + 10'd1;
                end
            end
            S_WAIT_WB: begin
                if (accelWrBlkDone) begin
                    w_nxtState = S_DONE;
                end
            end
            S_DONE: begin
                w_nxtState = S_IDLE;
            end
            default: begin
                w_nxtState = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so each one
    // reflects the state entered at the most recent edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= S_IDLE;
            r_stage           <= '0;
            r_cycle           <= '0;
            r_beat            <= '0;
            r_sigNumMC        <= '0;
            r_isIFFT          <= 1'b0;
            r_calculating     <= 1'b0;
            r_loadExternal    <= 1'b0;
            r_loadInternal    <= 1'b0;
            r_doneCalculating <= 1'b0;
            r_loadOutBuffer   <= 1'b0;
            r_done            <= 1'b0;
        end else begin
            r_state           <= w_nxtState;
            r_stage           <= w_nxtStage;
            r_cycle           <= w_nxtCycle;
            r_beat            <= w_nxtBeat;
            r_sigNumMC        <= w_nxtSigNum;
            r_isIFFT          <= w_nxtIsIfft;
            r_calculating     <= (w_nxtState != S_IDLE);
            r_loadExternal    <= (w_nxtState == S_LOAD_EXT);
            r_loadInternal    <= (w_nxtState == S_CALC);
            r_doneCalculating <= (w_nxtState == S_CDONE);
            r_loadOutBuffer   <= (w_nxtState == S_LOAD_OUT);
            r_done            <= (w_nxtState == S_DONE);
        end
    end

    assign calculating     = r_calculating;
    assign isIFFT          = r_isIFFT;
    assign sigNumMC        = r_sigNumMC;
    assign loadExternal    = r_loadExternal;
    assign loadInternal    = r_loadInternal;
    assign stageCount      = r_stage;
    assign cycleCount      = r_cycle;
    assign doneCalculating = r_doneCalculating;
    assign loadOutBuffer   = r_loadOutBuffer;
    assign done            = r_done;

endmodule
`default_nettype wire

// File: tb/tb_fft_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_seq_ctrl
// Description : Self-checking bench for fft_seq_ctrl. Each transform is run
//               phase by phase with randomized handshake delays and ignored
//               noise on out-of-phase inputs; every cycle the observed output
//               word is compared with one computed from the phase and the
//               cycle index within that phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_seq_ctrl;

    localparam int NS  = 10;
    localparam int CPS = 512;
    localparam int OB  = 1024;
`ifdef FFT_CTRL_FILTER_EN
    localparam bit FILT_EN = 1'b1;
`else
    localparam bit FILT_EN = 1'b0;
`endif

    // Bench-side phase names (independent of the design's encoding).
    localparam int P_IDLE = 0, P_WIN = 1, P_LDEXT = 2, P_CALC = 3, P_FILT = 4,
                   P_CDONE = 5, P_LOUT = 6, P_WWB = 7, P_DONE = 8;

    logic        clk;
    logic        rst;
    logic        startF, startI, filter;
    logic [17:0] sigNum;
    logic        inFifoReady, loadExternalDone, accelWrBlkDone;
    logic        calculating, isIFFT, loadExternal, loadInternal;
    logic [17:0] sigNumMC;
    logic [4:0]  stageCount;
    logic [8:0]  cycleCount;
    logic        filterActive, doneCalculating, loadOutBuffer, done;
    logic [20:0] w_status;

    int nChecks = 0;
    int nFails  = 0;

    fft_seq_ctrl #(
        .NUM_STAGES      (NS),
        .CYCLES_PER_STAGE(CPS),
        .OUT_BEATS       (OB)
    ) u_dut (
        .clk             (clk),
        .rst             (rst),
        .startF          (startF),
        .startI          (startI),
        .filter          (filter),
        .sigNum          (sigNum),
        .inFifoReady     (inFifoReady),
        .loadExternalDone(loadExternalDone),
        .accelWrBlkDone  (accelWrBlkDone),
        .calculating     (calculating),
        .isIFFT          (isIFFT),
        .sigNumMC        (sigNumMC),
        .loadExternal    (loadExternal),
        .loadInternal    (loadInternal),
        .stageCount      (stageCount),
        .cycleCount      (cycleCount),
        .filterActive    (filterActive),
        .doneCalculating (doneCalculating),
        .loadOutBuffer   (loadOutBuffer),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_status = {calculating, loadExternal, loadInternal, filterActive,
                       doneCalculating, loadOutBuffer, done, stageCount, cycleCount};

    task automatic checkValue(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            if (nFails <= 20)
                $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected output word for cycle k of a given phase.
    function automatic logic [20:0] expWord(input int ph, input int k);
        logic [4:0] stg;
        logic [8:0] cyc;
        stg = '0;
        cyc = '0;
        if (ph == P_CALC) begin
            stg = 5'(k / CPS);
            cyc = 9'(k % CPS);
        end else if (ph == P_FILT) begin
            cyc = 9'(k);
        end
        return {ph != P_IDLE, ph == P_LDEXT, ph == P_CALC, ph == P_FILT,
                ph == P_CDONE, ph == P_LOUT, ph == P_DONE, stg, cyc};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        startF = 1'b0; startI = 1'b0; filter = 1'b0;
        inFifoReady = 1'b0; loadExternalDone = 1'b0; accelWrBlkDone = 1'b0;
    endtask

    task automatic idleNoise(input int n);
        for (int i = 0; i < n; i++) begin
            checkValue("idle", w_status, expWord(P_IDLE, 0));
            inFifoReady      = 1'($urandom);
            loadExternalDone = 1'($urandom);
            accelWrBlkDone   = 1'($urandom);
            tick();
        end
        clearInputs();
    endtask

    // One transform. restartK / abortK select a CALC cycle for a busy start
    // or a reset; -1 disables them.
    task automatic runTransform(input bit sF, input bit sI, input bit flt,
                                input logic [17:0] sig, input int waitIn,
                                input int waitLd, input int waitWb,
                                input int restartK, input int abortK);
        bit expIfft;
        bit expFilt;
        expIfft = sI & ~sF;
        expFilt = flt & FILT_EN;

        startF = sF; startI = sI; filter = flt; sigNum = sig;
        tick();
        startF = 1'b0; startI = 1'b0; filter = 1'($urandom); sigNum = 18'($urandom);
        checkValue("start_sigNumMC", 32'(sigNumMC), 32'(sig));
        checkValue("start_isIFFT", 32'(isIFFT), 32'(expIfft));

        for (int w = 0; w <= waitIn; w++) begin
            checkValue("wait_in", w_status, expWord(P_WIN, 0));
            loadExternalDone = 1'($urandom);
            accelWrBlkDone   = 1'($urandom);
            inFifoReady      = (w == waitIn);
            tick();
        end
        clearInputs();

        for (int w = 0; w <= waitLd; w++) begin
            checkValue("load_ext", w_status, expWord(P_LDEXT, 0));
            inFifoReady      = 1'($urandom);
            accelWrBlkDone   = 1'($urandom);
            loadExternalDone = (w == waitLd);
            tick();
        end
        clearInputs();

        for (int k = 0; k < NS * CPS; k++) begin
            checkValue("calc", w_status, expWord(P_CALC, k));
            if (k == abortK) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                checkValue("abort_status", w_status, expWord(P_IDLE, 0));
                checkValue("abort_sigNumMC", 32'(sigNumMC), 32'd0);
                checkValue("abort_isIFFT", 32'(isIFFT), 32'd0);
                return;
            end
            startF      = (k == restartK);
            sigNum      = 18'($urandom);
            inFifoReady = 1'($urandom);
            tick();
        end
        clearInputs();

        if (expFilt) begin
            for (int k = 0; k < CPS; k++) begin
                checkValue("filt", w_status, expWord(P_FILT, k));
                tick();
            end
        end

        checkValue("cdone", w_status, expWord(P_CDONE, 0));
        tick();

        for (int k = 0; k < OB; k++) begin
            checkValue("load_out", w_status, expWord(P_LOUT, k));
            accelWrBlkDone = 1'($urandom);
            tick();
        end
        clearInputs();

        for (int w = 0; w <= waitWb; w++) begin
            checkValue("wait_wb", w_status, expWord(P_WWB, 0));
            inFifoReady      = 1'($urandom);
            loadExternalDone = 1'($urandom);
            accelWrBlkDone   = (w == waitWb);
            tick();
        end
        clearInputs();

        checkValue("done", w_status, expWord(P_DONE, 0));
        tick();
        checkValue("after_done", w_status, expWord(P_IDLE, 0));
        checkValue("held_sigNumMC", 32'(sigNumMC), 32'(sig));
        checkValue("held_isIFFT", 32'(isIFFT), 32'(expIfft));
    endtask

    initial begin
        bit rf;
        rst = 1'b1;
        sigNum = '0;
        clearInputs();
        tick();
        tick();
        checkValue("reset_status", w_status, expWord(P_IDLE, 0));
        checkValue("reset_sigNumMC", 32'(sigNumMC), 32'd0);
        checkValue("reset_isIFFT", 32'(isIFFT), 32'd0);
        rst = 1'b0;
        idleNoise(5);

        // Nominal forward transform, RAM load done three cycles in.
        runTransform(1'b1, 1'b0, 1'($urandom), 18'h00001, $urandom_range(0, 2), 3, 0, -1, -1);
        // Simultaneous starts: forward wins.
        runTransform(1'b1, 1'b1, 1'($urandom), 18'($urandom), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), -1, -1);
        // Inverse alone, with a busy restart during stage 3.
        runTransform(1'b0, 1'b1, 1'($urandom), 18'($urandom), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), 3 * CPS + 17, -1);
        // Reset at stage 5 / cycle 100, then a full forward transform.
        runTransform(1'b0, 1'b1, 1'($urandom), 18'($urandom), 1, 1, 1, -1, 5 * CPS + 100);
        idleNoise(3);
        runTransform(1'b1, 1'b0, 1'($urandom), 18'($urandom), 0, 0, 0, -1, -1);
        // Stalled handshakes.
        runTransform(1'b0, 1'b1, 1'($urandom), 18'($urandom), 50, $urandom_range(0, 4), 50, -1, -1);
        // Filter request explicitly set; FILT only exists when the macro is on.
        rf = 1'($urandom);
        runTransform(rf, ~rf, 1'b1, 18'($urandom), $urandom_range(0, 4),
                     $urandom_range(0, 4), $urandom_range(0, 4), -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
`default_nettype wire
